// File: rtl/aftab_seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU) with start/busy/done handshake.
// Optional abort input enabled by defining AFTAB_SEQ_DIVIDER_ABORT_EN.
module aftab_seq_divider #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
`ifdef AFTAB_SEQ_DIVIDER_ABORT_EN
  input  logic            abort,
`endif
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            busy,
  output logic            done
);

  localparam int cw = $clog2(size + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_reg;
  logic [size-1:0] a_reg;
  logic [size-1:0] b_reg;
  logic [size-1:0] p_reg;
  logic [size-1:0] orig_reg;
  logic [cw-1:0]   counter_reg;
  logic            q_neg_reg;
  logic            r_neg_reg;
  logic            div0_reg;
  logic            ovf_reg;

  logic [size:0]   p_shift;
  logic [size:0]   trial;
  logic [size-1:0] dividend_mag;
  logic [size-1:0] divisor_mag;
  logic            is_div0;
  logic            is_ovf;
  logic            abort_hit;

  assign p_shift      = {p_reg, a_reg[size-1]};
  assign trial        = p_shift - {1'b0, b_reg};
  assign dividend_mag = (signed_op & dividend[size-1]) ? -dividend : dividend;
  assign divisor_mag  = (signed_op & divisor[size-1])  ? -divisor  : divisor;
  assign is_div0      = (divisor == '0);
  assign is_ovf       = signed_op & (dividend == {1'b1, {(size-1){1'b0}}}) & (divisor == '1);

`ifdef AFTAB_SEQ_DIVIDER_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      p_reg       <= '0;
      orig_reg    <= '0;
      counter_reg <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      div0_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg       <= dividend_mag;
            b_reg       <= divisor_mag;
            p_reg       <= '0;
            orig_reg    <= dividend;
            q_neg_reg   <= signed_op & (dividend[size-1] ^ divisor[size-1]);
            r_neg_reg   <= signed_op & dividend[size-1];
            div0_reg    <= is_div0;
            ovf_reg     <= is_ovf;
            counter_reg <= cw'(size);
            busy        <= 1'b1;
            state_reg   <= (is_div0 | is_ovf) ? FIX : CALC;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        CALC: begin
          if (abort_hit) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            // Restoring step: keep the trial only when it did not go negative.
            if (!trial[size]) begin
              p_reg <= trial[size-1:0];
              a_reg <= {a_reg[size-2:0], 1'b1};
            end else begin
              p_reg <= p_shift[size-1:0];
              a_reg <= {a_reg[size-2:0], 1'b0};
            end
            counter_reg <= counter_reg - cw'(1);
            if (counter_reg == cw'(1))
              state_reg <= FIX;
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (abort_hit) begin
            state_reg <= IDLE;
          end else begin
            if (div0_reg) begin
              quotient  <= '1;
              remainder <= orig_reg;
            end else if (ovf_reg) begin
              quotient  <= orig_reg;
              remainder <= '0;
            end else begin
              quotient  <= q_neg_reg ? -a_reg : a_reg;
              remainder <= r_neg_reg ? -p_reg : p_reg;
            end
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
